// File: rtl/change_payout_if.sv
// Coin-payout bundle between the vending controller / coin hoppers and
// change_payout. master = controller and hopper side, slave = payout engine.
interface change_payout_if #(
  parameter int AMT_W = 9
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             coin_ack;
  logic [3:0]       hopper_empty;
  logic [3:0]       eject;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] quarter_cnt;
  logic [AMT_W-1:0] dime_cnt;
  logic [AMT_W-1:0] nickel_cnt;
  logic [AMT_W-1:0] penny_cnt;

  modport master (
    output start, amount, coin_ack, hopper_empty,
    input  eject, busy, done, fault, remaining,
           quarter_cnt, dime_cnt, nickel_cnt, penny_cnt
  );

  modport slave (
    input  start, amount, coin_ack, hopper_empty,
    output eject, busy, done, fault, remaining,
           quarter_cnt, dime_cnt, nickel_cnt, penny_cnt
  );
endinterface

// File: rtl/change_payout.sv
// Change payout engine: splits a cent amount greedily into quarters, dimes,
// nickels and pennies, drives one hopper at a time and waits for each coin's
// sensor ack. Empty or jammed hoppers make it fall back to smaller coins;
// whatever cannot be paid is left in remaining with fault set.
module change_payout #(
  parameter int AMT_W        = 9,
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 1000
) (
  input logic            clk,
  input logic            rst,
  change_payout_if.slave bus
);

  localparam int PT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int AT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [PT_W-1:0] PULSE_LAST = PT_W'(PULSE_CYCLES - 1);
  localparam logic [AT_W-1:0] ACK_LAST   = AT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    DONE
  } state_t;

  // Hopper index: 3=quarter, 2=dime, 1=nickel, 0=penny.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] d);
    case (d)
      2'd3:    return AMT_W'(25);
      2'd2:    return AMT_W'(10);
      2'd1:    return AMT_W'(5);
      default: return AMT_W'(1);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [PT_W-1:0]  ptmr_q, ptmr_d;
  logic [AT_W-1:0]  atmr_q, atmr_d;
  logic [3:0]       jam_q, jam_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] cnt_q [4];
  logic [AMT_W-1:0] cnt_d [4];
  logic             fault_q, fault_d;
  logic [3:0]       eject_q, eject_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       unavail;
  logic             pick_ok;
  logic [1:0]       pick;
  logic [AMT_W-1:0] sel_val;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptmr_d  = ptmr_q;
    atmr_d  = atmr_q;
    jam_d   = jam_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    eject_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unavail = bus.hopper_empty | jam_q;
    pick_ok = 1'b0;
    pick    = '0;
    // Ascending scan: the highest usable denomination wins.
    for (int unsigned i = 0; i < 4; i++) begin
      if (!unavail[i] && (coin_value(2'(i)) <= rem_q)) begin
        pick_ok = 1'b1;
        pick    = 2'(i);
      end
    end
    sel_val = coin_value(sel_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d   = bus.amount;
          cnt_d   = '{default: '0};
          fault_d = 1'b0;
          jam_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end else if (pick_ok) begin
          sel_d   = pick;
          ptmr_d  = '0;
          state_d = EJECT;
        end else begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      EJECT: begin
        if (bus.coin_ack) begin
          rem_d        = rem_q - sel_val;
          cnt_d[sel_q] = cnt_q[sel_q] + AMT_W'(1);
          state_d      = SELECT;
        end else if (ptmr_q == PULSE_LAST) begin
          atmr_d  = '0;
          state_d = WAIT_ACK;
        end else begin
          ptmr_d = ptmr_q + PT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (bus.coin_ack) begin
          rem_d        = rem_q - sel_val;
          cnt_d[sel_q] = cnt_q[sel_q] + AMT_W'(1);
          state_d      = SELECT;
        end else if (atmr_q == ACK_LAST) begin
          jam_d[sel_q] = 1'b1;
          state_d      = SELECT;
        end else begin
          atmr_d = atmr_q + AT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    eject_d = (state_d == EJECT) ? (4'b0001 << sel_d) : '0;
    busy_d  = (state_d == SELECT) || (state_d == EJECT) || (state_d == WAIT_ACK);
    done_d  = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptmr_q  <= '0;
      atmr_q  <= '0;
      jam_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '{default: '0};
      fault_q <= 1'b0;
      eject_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptmr_q  <= ptmr_d;
      atmr_q  <= atmr_d;
      jam_q   <= jam_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      eject_q <= eject_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.eject       = eject_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;
  assign bus.remaining   = rem_q;
  assign bus.quarter_cnt = cnt_q[3];
  assign bus.dime_cnt    = cnt_q[2];
  assign bus.nickel_cnt  = cnt_q[1];
  assign bus.penny_cnt   = cnt_q[0];

endmodule

// File: tb/tb_change_payout.sv
// Bench for change_payout: directed table of transactions, hand-written reset
// and ignored-start sequences, and random transactions against a greedy model.
module tb_change_payout;

  localparam int AMT_W  = 9;
  localparam int PULSE  = 4;
  localparam int TO     = 50;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  change_payout_if #(.AMT_W(AMT_W)) bus ();

  change_payout #(
    .AMT_W(AMT_W),
    .PULSE_CYCLES(PULSE),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Hopper behaviour: ack a coin ack_delay cycles after its eject rises,
  // unless that hopper is marked as never acking (jammed).
  int         ack_delay  = 2;
  logic [3:0] noack_mask = '0;
  int         pend       = -1;
  logic [3:0] rsp_prev   = '0;

  always @(negedge clk) begin
    bus.coin_ack = 1'b0;
    if (rst) begin
      pend     = -1;
      rsp_prev = '0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.coin_ack = 1'b1;
          pend = -1;
        end
      end
      if (bus.eject != 0 && rsp_prev == 0 && (bus.eject & noack_mask) == 0)
        pend = ack_delay;
      rsp_prev = bus.eject;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: greedy change from the rules, plus expected eject episodes
  // and the number of cycles from start acceptance until DONE.
  int m_cnt [4];
  int m_rem, m_fault, m_cycles;
  int exp_val [$];
  int exp_len [$];

  task automatic model(input int amount, input logic [3:0] empty,
                       input logic [3:0] noack, input int delay);
    int vals [4];
    logic [3:0] jam;
    int pick;
    vals = '{1, 5, 10, 25};
    jam = '0;
    m_rem = amount; m_fault = 0; m_cycles = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    exp_val.delete(); exp_len.delete();
    forever begin
      m_cycles++;
      if (m_rem == 0) break;
      pick = -1;
      for (int d = 3; d >= 0; d--)
        if (pick < 0 && vals[d] <= m_rem && !empty[d] && !jam[d]) pick = d;
      if (pick < 0) begin
        m_fault = 1;
        break;
      end
      exp_val.push_back(1 << pick);
      if (noack[pick]) begin
        jam[pick] = 1'b1;
        exp_len.push_back(PULSE);
        m_cycles += PULSE + TO;
      end else begin
        m_cnt[pick]++;
        m_rem -= vals[pick];
        exp_len.push_back((delay + 1 < PULSE) ? delay + 1 : PULSE);
        m_cycles += delay + 1;
      end
    end
  endtask

  int obs_val [$];
  int obs_len [$];

  task automatic run_txn(input string tag, input int amount, input logic [3:0] empty,
                         input logic [3:0] noack, input int delay, input int stray_at);
    int obs, len, got;
    logic [3:0] prev, ej;
    int n;
    model(amount, empty, noack, delay);
    bus.hopper_empty = empty;
    noack_mask = noack;
    ack_delay = delay;
    obs_val.delete(); obs_len.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.amount = AMT_W'(amount);
    @(negedge clk);
    obs = 1; got = 0; len = 0; prev = '0;
    chk({tag, " busy_after_start"}, int'(bus.busy), 1);
    forever begin
      ej = bus.eject;
      if (ej != 0) begin
        if (prev == 0) begin
          obs_val.push_back(int'(ej));
          len = 1;
        end else len++;
      end else if (prev != 0) obs_len.push_back(len);
      prev = ej;
      bus.start = (obs == stray_at);
      if (obs == stray_at) bus.amount = AMT_W'(5);
      if (bus.done) begin
        got = 1;
        break;
      end
      if (obs >= BUDGET) break;
      @(negedge clk);
      obs++;
    end
    bus.start = 1'b0;
    chk({tag, " done_seen"}, got, 1);
    chk({tag, " latency"}, obs, m_cycles + 1);
    chk({tag, " busy_at_done"}, int'(bus.busy), 0);
    chk({tag, " m_quarter"}, int'(bus.quarter_cnt), m_cnt[3]);
    chk({tag, " m_dime"}, int'(bus.dime_cnt), m_cnt[2]);
    chk({tag, " m_nickel"}, int'(bus.nickel_cnt), m_cnt[1]);
    chk({tag, " m_penny"}, int'(bus.penny_cnt), m_cnt[0]);
    chk({tag, " m_remaining"}, int'(bus.remaining), m_rem);
    chk({tag, " m_fault"}, int'(bus.fault), m_fault);
    chk({tag, " eject_count"}, obs_val.size(), exp_val.size());
    n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s eject_val[%0d]", tag, i), obs_val[i], exp_val[i]);
      if (i < obs_len.size())
        chk($sformatf("%s eject_len[%0d]", tag, i), obs_len[i], exp_len[i]);
    end
    @(negedge clk);
    chk({tag, " done_one_cycle"}, int'(bus.done), 0);
  endtask

  typedef struct {
    int         amount;
    logic [3:0] empty;
    logic [3:0] noack;
    int         delay;
    int         q, d, n, p;
    int         rem;
    int         fault;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int rises, k, dones, ejects;
    logic [3:0] prev;

    vecs[0] = '{41,  4'b0000, 4'b0000, 2, 1, 1, 1, 1, 0, 0};
    vecs[1] = '{30,  4'b1000, 4'b0000, 2, 0, 3, 0, 0, 0, 0};
    vecs[2] = '{7,   4'b0001, 4'b0000, 2, 0, 0, 1, 0, 2, 1};
    vecs[3] = '{25,  4'b0000, 4'b1000, 2, 0, 2, 1, 0, 0, 0};
    vecs[4] = '{0,   4'b0000, 4'b0000, 2, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{99,  4'b0000, 4'b0000, 1, 3, 2, 0, 4, 0, 0};
    vecs[6] = '{13,  4'b0110, 4'b0000, 3, 0, 0, 0, 13, 0, 0};
    vecs[7] = '{6,   4'b0011, 4'b0000, 2, 0, 0, 0, 0, 6, 1};
    vecs[8] = '{511, 4'b0000, 4'b0000, 2, 20, 1, 0, 1, 0, 0};
    vecs[9] = '{40,  4'b0000, 4'b0100, 5, 1, 0, 3, 0, 0, 0};

    bus.start = 1'b0;
    bus.amount = '0;
    bus.hopper_empty = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset eject", int'(bus.eject), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset fault", int'(bus.fault), 0);
    chk("reset remaining", int'(bus.remaining), 0);
    chk("reset counts", int'(bus.quarter_cnt) + int'(bus.dime_cnt)
                        + int'(bus.nickel_cnt) + int'(bus.penny_cnt), 0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_txn(tag, vecs[i].amount, vecs[i].empty, vecs[i].noack, vecs[i].delay, 0);
      chk({tag, " quarter"}, int'(bus.quarter_cnt), vecs[i].q);
      chk({tag, " dime"}, int'(bus.dime_cnt), vecs[i].d);
      chk({tag, " nickel"}, int'(bus.nickel_cnt), vecs[i].n);
      chk({tag, " penny"}, int'(bus.penny_cnt), vecs[i].p);
      chk({tag, " remaining"}, int'(bus.remaining), vecs[i].rem);
      chk({tag, " fault"}, int'(bus.fault), vecs[i].fault);
    end

    // Start pulsed mid-transaction is ignored: result is that of amount=41.
    run_txn("stray_start", 41, 4'b0000, 4'b0000, 2, 3);
    chk("stray quarter", int'(bus.quarter_cnt), 1);
    chk("stray penny", int'(bus.penny_cnt), 1);
    chk("stray remaining", int'(bus.remaining), 0);
    repeat (3) @(negedge clk);
    chk("stray no second txn", int'(bus.busy), 0);

    // Reset during the second eject abandons the transaction.
    bus.hopper_empty = '0;
    noack_mask = '0;
    ack_delay = 2;
    @(negedge clk);
    bus.start = 1'b1;
    bus.amount = AMT_W'(41);
    @(negedge clk);
    bus.start = 1'b0;
    rises = 0; k = 0; prev = '0;
    while (rises < 2 && k < 200) begin
      if (bus.eject != 0 && prev == 0) rises++;
      prev = bus.eject;
      if (rises < 2) begin
        @(negedge clk);
        k++;
      end
    end
    chk("rst second eject", int'(bus.eject), 4);
    chk("rst quarter before", int'(bus.quarter_cnt), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst eject", int'(bus.eject), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst quarter", int'(bus.quarter_cnt), 0);
    chk("rst remaining", int'(bus.remaining), 0);
    rst = 1'b0;
    dones = 0; ejects = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.eject != 0) ejects++;
    end
    chk("rst no done", dones, 0);
    chk("rst no eject", ejects, 0);

    // Random transactions against the model.
    for (int i = 0; i < 25; i++) begin
      int amt, dly;
      logic [3:0] emp, nak;
      amt = $urandom_range(0, 160);
      emp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      nak = ($urandom_range(0, 2) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      dly = $urandom_range(1, 7);
      run_txn($sformatf("rand%0d", i), amt, emp, nak, dly, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
